// File: rtl/mux_arbiter.sv
// Round-robin owner arbiter for a shared 4-input multiplexer: one-hot grants,
// select equal to the owner index, and forced rotation after MAX_HOLD cycles.
module mux_arbiter #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] s,
  output logic       valid,
  output logic       preempt,
  output logic [1:0] state_dbg
);

  // Handshake: a requester raises req and holds it for the whole use of the
  // resource; grant answers one edge later and every hand-over has one dead cycle.
  localparam int         CW   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [3:0] MASK = 4'((1 << N) - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_grant;
  logic [1:0]      r_s;
  logic            r_valid;
  logic            r_preempt;
  logic [1:0]      r_ptr;
  logic [CW-1:0]   r_cnt;

  logic [3:0]      w_grant_nxt;
  logic [1:0]      w_s_nxt;
  logic            w_valid_nxt;
  logic            w_preempt_nxt;
  logic [1:0]      w_ptr_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  logic [3:0]      w_mreq;
  logic            w_found;
  logic [1:0]      w_win;
  logic            w_release;
  logic            w_force;
  logic            w_at_limit;
  logic [1:0]      w_ptr_after;

  assign w_mreq     = req & MASK;
  assign w_release  = ~req[r_s];
  assign w_at_limit = (MAX_HOLD != 0) && (r_cnt == CW'(MAX_HOLD));
  assign w_force    = w_at_limit && (|(w_mreq & ~r_grant));

  // Pointer after the current owner leaves; with N=1 it never moves off 0.
  always_comb begin
    w_ptr_after = 2'd0;
    if (N > 1 && int'(r_s) != N - 1) begin
      w_ptr_after = r_s + 2'd1;
    end
  end

  // Search ptr, ptr+1, ... modulo N; the first set masked request wins.
  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_win   = 2'd0;
    v_idx   = 0;
    for (int i = 0; i < N; i++) begin
      v_idx = int'(r_ptr) + i;
      if (v_idx >= N) begin
        v_idx = v_idx - N;
      end
      if (!w_found && w_mreq[2'(v_idx)]) begin
        w_found = 1'b1;
        w_win   = 2'(v_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_state_nxt = ST_OWN;
      ST_OWN:  if (w_release || w_force) w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = w_found ? ST_OWN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_grant_nxt   = r_grant;
    w_s_nxt       = r_s;
    w_valid_nxt   = r_valid;
    w_preempt_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_found) begin
          w_grant_nxt = 4'd1 << w_win;
          w_s_nxt     = w_win;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = CW'(1);
        end else begin
          w_grant_nxt = 4'd0;
          w_valid_nxt = 1'b0;
        end
      end
      ST_OWN: begin
        if (w_release || w_force) begin
          w_grant_nxt   = 4'd0;
          w_valid_nxt   = 1'b0;
          w_ptr_nxt     = w_ptr_after;
          w_preempt_nxt = ~w_release;
        end else if (MAX_HOLD != 0 && !w_at_limit) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_grant_nxt = 4'd0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant   <= 4'd0;
      r_s       <= 2'd0;
      r_valid   <= 1'b0;
      r_preempt <= 1'b0;
      r_ptr     <= 2'd0;
      r_cnt     <= '0;
    end else begin
      r_grant   <= w_grant_nxt;
      r_s       <= w_s_nxt;
      r_valid   <= w_valid_nxt;
      r_preempt <= w_preempt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign grant     = r_grant;
  assign s         = r_s;
  assign valid     = r_valid;
  assign preempt   = r_preempt;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: three parameterisations share clock and reset,
// each exercised with hand-computed grant/select/valid/preempt sequences.
module tb_mux_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req2, req4, req3;
  logic [3:0] grant2, grant4, grant3;
  logic [1:0] s2, s4, s3;
  logic       valid2, valid4, valid3;
  logic       pre2, pre4, pre3;
  logic [1:0] st2, st4, st3;

  int n_checks;
  int n_errors;

  mux_arbiter #(.N(2), .MAX_HOLD(16)) u2 (
    .clk(clk), .rst(rst), .req(req2), .grant(grant2), .s(s2),
    .valid(valid2), .preempt(pre2), .state_dbg(st2)
  );
  mux_arbiter #(.N(4), .MAX_HOLD(4)) u4 (
    .clk(clk), .rst(rst), .req(req4), .grant(grant4), .s(s4),
    .valid(valid4), .preempt(pre4), .state_dbg(st4)
  );
  mux_arbiter #(.N(3), .MAX_HOLD(2)) u3 (
    .clk(clk), .rst(rst), .req(req3), .grant(grant3), .s(s3),
    .valid(valid3), .preempt(pre3), .state_dbg(st3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp2(input string tag, input logic [3:0] g, input logic [1:0] sel,
                      input logic v, input logic p);
    check({tag, ".grant"}, 8'(grant2), 8'(g));
    check({tag, ".s"}, 8'(s2), 8'(sel));
    check({tag, ".valid"}, 8'(valid2), 8'(v));
    check({tag, ".preempt"}, 8'(pre2), 8'(p));
  endtask

  task automatic exp4(input string tag, input logic [3:0] g, input logic [1:0] sel,
                      input logic v, input logic p);
    check({tag, ".grant"}, 8'(grant4), 8'(g));
    check({tag, ".s"}, 8'(s4), 8'(sel));
    check({tag, ".valid"}, 8'(valid4), 8'(v));
    check({tag, ".preempt"}, 8'(pre4), 8'(p));
  endtask

  task automatic exp3(input string tag, input logic [3:0] g, input logic [1:0] sel,
                      input logic v, input logic p);
    check({tag, ".grant"}, 8'(grant3), 8'(g));
    check({tag, ".s"}, 8'(s3), 8'(sel));
    check({tag, ".valid"}, 8'(valid3), 8'(v));
    check({tag, ".preempt"}, 8'(pre3), 8'(p));
  endtask

  // Fairness table for N=3, MAX_HOLD=2 with all requests high.
  logic [3:0] fair_g [10];
  logic [1:0] fair_s [10];
  logic       fair_p [10];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b1;
    req2 = 4'd0;
    req4 = 4'd0;
    req3 = 4'd0;
    fair_g = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010,
               4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0001};
    fair_s = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
    fair_p = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    step();
    step();
    exp2("rst_u2", 4'b0000, 2'd0, 1'b0, 1'b0);
    exp4("rst_u4", 4'b0000, 2'd0, 1'b0, 1'b0);
    exp3("rst_u3", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic grant and rotation, N=2.
    req2 = 4'b0011;
    step();
    exp2("basic", 4'b0001, 2'd0, 1'b1, 1'b0);
    req2 = 4'b0010;
    step();
    exp2("rot_gap1", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    exp2("rot_own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req2 = 4'b0001;
    step();
    exp2("rot_gap2", 4'b0000, 2'd1, 1'b0, 1'b0);
    step();
    exp2("rot_own0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Reach owner 1, then reset mid-OWN while requests stay high.
    req2 = 4'b0010;
    step();
    exp2("pre_rst_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    exp2("pre_rst_own", 4'b0010, 2'd1, 1'b1, 1'b0);
    req2 = 4'b0011;
    rst  = 1'b1;
    step();
    exp2("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    exp2("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Masking: requesters 2 and 3 are beyond N=2.
    req2 = 4'b0000;
    step();
    step();
    exp2("idle_u2", 4'b0000, 2'd0, 1'b0, 1'b0);
    req2 = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      step();
      exp2("mask", 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    req2 = 4'b0000;

    // Preemption, N=4, MAX_HOLD=4: owner 0 holds exactly 4 cycles.
    req4 = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step();
      exp4("hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step();
    exp4("preempt_gap", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    exp4("preempt_own3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req4 = 4'b0000;
    step();
    exp4("rel3_gap", 4'b0000, 2'd3, 1'b0, 1'b0);
    step();
    exp4("rel3_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Solo owner is never preempted.
    req4 = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      exp4("solo2", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    req4 = 4'b0000;
    step();
    exp4("solo_rel", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Fairness, N=3, MAX_HOLD=2: 0,1,2,0 with one GAP between owners.
    req3 = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      step();
      exp3($sformatf("fair%0d", i), fair_g[i], fair_s[i], |fair_g[i], fair_p[i]);
    end
    req3 = 4'b0000;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
